// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned M0 = 0;
  localparam int unsigned M1 = 1;

  localparam int unsigned LOCK_CNT_W = 8;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

endpackage

// File: rtl/mem_arbiter2_rr_pick.sv
// Combinational 2-way pick: round-robin against the last winner, or M0-first when prio is set.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio || (last == 1'(M1))) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master arbiter in front of a single-access memory: round-robin or fixed priority,
// optional bus lock with bounded run length, and one-cycle read data return routing.
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_rready,
  output logic        mem_wready,
  output logic [29:0] mem_raddr,
  output logic [29:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  arb_state_e  state_q, state_d;
  lock_cnt_t   cnt_q, cnt_d, cnt_inc;
  logic        last_q, last_d;
  logic        rpend_q, rpend_d;
  logic        rsel_q, rsel_d;
  logic [1:0]  pick, gnt;
  logic        win, granted, win_we, win_lock, release_own;
  logic [29:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .prio (FIXED_PRIO),
    .gnt  (pick)
  );

  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ARB_OWN0: gnt = {1'b0, m0_req};
      ARB_OWN1: gnt = {m1_req, 1'b0};
      default:  gnt = pick;
    endcase
    // No transfer is accepted while reset is held.
    if (reset) gnt = 2'b00;
  end

  assign win       = gnt[1];
  assign granted   = |gnt;
  assign win_we    = win ? m1_we    : m0_we;
  assign win_lock  = win ? m1_lock  : m0_lock;
  assign win_addr  = win ? m1_addr  : m0_addr;
  assign win_wdata = win ? m1_wdata : m0_wdata;
  assign win_wstrb = win ? m1_wstrb : m0_wstrb;

  // The grant that opens a locked run counts as the first one of that run.
  always_comb begin
    cnt_inc = 1;
    if (state_q != ARB_IDLE) begin
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign release_own = !win_lock || ((LOCK_MAX != 0) && (32'(cnt_inc) >= LOCK_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rpend_d = 1'b0;
    rsel_d  = rsel_q;
    if (granted) begin
      last_d = win;
      if (!win_we) begin
        rpend_d = 1'b1;
        rsel_d  = win;
      end
      if (release_own) begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = win ? ARB_OWN1 : ARB_OWN0;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'(M1);
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
    end
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign mem_rready = granted & ~win_we;
  assign mem_wready = granted & win_we;
  assign mem_raddr  = granted ? win_addr : '0;
  assign mem_waddr  = granted ? win_addr : '0;
  assign mem_wdata  = mem_wready ? win_wdata : '0;
  assign mem_wstrb  = mem_wready ? win_wstrb : '0;

  assign m0_rvalid = rpend_q & ~reset & (rsel_q == 1'(M0));
  assign m1_rvalid = rpend_q & ~reset & (rsel_q == 1'(M1));
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
